// File: rtl/io_bridge_fx_if.sv
// Processor I/O bus plus upstream/downstream stream signals of the io_bridge_fx responder.
// The slave modport is the bridge side; master is the processor/stream side.
interface io_bridge_fx_if #(
   parameter int NUBITS = 16,
   parameter int NUIOIN = 2,
   parameter int NUIOOU = 2
);
   localparam int AIW = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
   localparam int AOW = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;

   logic [NUBITS-1:0]        io_in;
   logic [NUBITS-1:0]        io_out;
   logic [AIW-1:0]           addr_in;
   logic [AOW-1:0]           addr_out;
   logic                     req_in;
   logic                     out_en;
   logic                     itr;
   logic [NUIOIN*NUBITS-1:0] in_data;
   logic [NUIOIN-1:0]        in_valid;
   logic [NUIOIN-1:0]        in_ready;
   logic [NUBITS-1:0]        out_data;
   logic [AOW-1:0]           out_addr;
   logic                     out_valid;
   logic                     out_ready;
   logic                     ovf;
   logic                     udf;

   modport slave (
      output io_in, itr, in_ready, out_data, out_addr, out_valid, ovf, udf,
      input  io_out, addr_in, addr_out, req_in, out_en, in_data, in_valid, out_ready
   );

   modport master (
      input  io_in, itr, in_ready, out_data, out_addr, out_valid, ovf, udf,
      output io_out, addr_in, addr_out, req_in, out_en, in_data, in_valid, out_ready
   );
endinterface

// File: rtl/io_bridge_fx.sv
// Peripheral responder: upstream streams become processor-readable input ports, processor
// writes become a tagged downstream stream through a FIFO, masked input loads raise itr.
module io_bridge_fx #(
   parameter int                NUBITS = 16,
   parameter int                NUIOIN = 2,
   parameter int                NUIOOU = 2,
   parameter int                ODEPTH = 4,
   parameter logic [NUIOIN-1:0] ITRMSK = '0
) (
   input  logic          clk,
   input  logic          rst,
   io_bridge_fx_if.slave bus
);
   localparam int AIW = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
   localparam int AOW = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;
   localparam int PW  = $clog2(ODEPTH);
   localparam int CW  = PW + 1;
   localparam int EW  = AOW + NUBITS;

   logic [NUBITS-1:0] data_q [NUIOIN];
   logic [NUBITS-1:0] data_d [NUIOIN];
   logic [NUIOIN-1:0] full_q, full_d;
   logic [NUIOIN-1:0] load_s;
   logic [NUBITS-1:0] io_in_s;
   logic              hit_full_s;

   logic [EW-1:0]     mem_q [ODEPTH];
   logic [EW-1:0]     mem_d [ODEPTH];
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [EW-1:0]     last_q, last_d;
   logic              push_s, pop_s;

   logic              itr_q, itr_d, ovf_q, ovf_d, udf_q, udf_d;

   // Input holding registers: load from upstream, pop on processor read.
   always_comb begin
      data_d     = data_q;
      full_d     = full_q;
      load_s     = '0;
      io_in_s    = '0;
      hit_full_s = 1'b0;
      for (int k = 0; k < NUIOIN; k++) begin
         load_s[k] = bus.in_valid[k] & ~full_q[k];
         if (load_s[k]) begin
            data_d[k] = bus.in_data[k*NUBITS +: NUBITS];
            full_d[k] = 1'b1;
         end else begin
            data_d[k] = data_q[k];
         end
         // Out-of-range addresses never match, so they read 0 and flag udf.
         if (bus.addr_in == AIW'(k)) begin
            io_in_s    = data_q[k];
            hit_full_s = full_q[k];
            if (bus.req_in && full_q[k]) begin
               full_d[k] = 1'b0;
            end else begin
               full_d[k] = full_d[k];
            end
         end else begin
            io_in_s = io_in_s;
         end
      end
      udf_d = udf_q | (bus.req_in & ~hit_full_s);
      itr_d = |(load_s & ITRMSK);
   end

   // Output FIFO: a push into a full queue is still accepted when the head leaves this cycle.
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      last_d   = last_q;
      pop_s    = (count_q != '0) & bus.out_ready;
      push_s   = bus.out_en & ((count_q < CW'(ODEPTH)) | pop_s);
      ovf_d    = ovf_q | (bus.out_en & ~push_s);
      if (push_s) begin
         mem_d[wr_ptr_q] = {bus.addr_out, bus.io_out};
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         last_d   = mem_q[rd_ptr_q];
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(push_s) - CW'(pop_s);
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q   <= '{default: '0};
         full_q   <= '0;
         mem_q    <= '{default: '0};
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         last_q   <= '0;
         itr_q    <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         data_q   <= data_d;
         full_q   <= full_d;
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         last_q   <= last_d;
         itr_q    <= itr_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   assign bus.io_in     = io_in_s;
   assign bus.in_ready  = ~full_q;
   assign bus.out_valid = (count_q != '0);
   assign bus.out_data  = (count_q != '0) ? mem_q[rd_ptr_q][NUBITS-1:0]  : last_q[NUBITS-1:0];
   assign bus.out_addr  = (count_q != '0) ? mem_q[rd_ptr_q][EW-1:NUBITS] : last_q[EW-1:NUBITS];
   assign bus.itr       = itr_q;
   assign bus.ovf       = ovf_q;
   assign bus.udf       = udf_q;
endmodule

// File: tb/tb_io_bridge_fx.sv
// Directed table-driven bench for io_bridge_fx, plus hand sequences for reset and full-FIFO corners.
module tb_io_bridge_fx;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   io_bridge_fx_if #(.NUBITS(16), .NUIOIN(2), .NUIOOU(2)) bus ();

   io_bridge_fx #(
      .NUBITS(16), .NUIOIN(2), .NUIOOU(2), .ODEPTH(4), .ITRMSK(2'b10)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  iv;
      logic [15:0] d0;
      logic [15:0] d1;
      logic        ai;
      logic        rq;
      logic        oe;
      logic        ao;
      logic [15:0] io;
      logic        ordy;
      logic [1:0]  e_rdy;
      logic [15:0] e_ioin;
      logic        e_ov;
      logic [15:0] e_od;
      logic        e_oa;
      logic        e_itr;
      logic        e_ovf;
      logic        e_udf;
   } vec_t;

   vec_t tbl [25];

   function automatic vec_t mk(
      input logic [1:0] iv, input logic [15:0] d0, input logic [15:0] d1,
      input logic ai, input logic rq, input logic oe, input logic ao,
      input logic [15:0] io, input logic ordy,
      input logic [1:0] e_rdy, input logic [15:0] e_ioin, input logic e_ov,
      input logic [15:0] e_od, input logic e_oa, input logic e_itr,
      input logic e_ovf, input logic e_udf);
      vec_t v;
      v.iv = iv; v.d0 = d0; v.d1 = d1; v.ai = ai; v.rq = rq; v.oe = oe; v.ao = ao;
      v.io = io; v.ordy = ordy; v.e_rdy = e_rdy; v.e_ioin = e_ioin; v.e_ov = e_ov;
      v.e_od = e_od; v.e_oa = e_oa; v.e_itr = e_itr; v.e_ovf = e_ovf; v.e_udf = e_udf;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] iv, input logic [15:0] d0, input logic [15:0] d1,
                        input logic ai, input logic rq, input logic oe, input logic ao,
                        input logic [15:0] io, input logic ordy);
      bus.in_valid  = iv;
      bus.in_data   = {d1, d0};
      bus.addr_in   = ai;
      bus.req_in    = rq;
      bus.out_en    = oe;
      bus.addr_out  = ao;
      bus.io_out    = io;
      bus.out_ready = ordy;
   endtask

   logic [15:0] drain_d [4];
   logic        drain_a [4];

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);

      //          iv     d0        d1        ai    rq    oe    ao    io        ordy  e_rdy  e_ioin    ov    od        oa    itr   ovf   udf
      tbl[0]  = mk(2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 2'b11, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[1]  = mk(2'b10, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 2'b11, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[2]  = mk(2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 2'b01, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
      tbl[3]  = mk(2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 2'b01, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[4]  = mk(2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 2'b11, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[5]  = mk(2'b01, 16'h00BE, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 2'b11, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[6]  = mk(2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 2'b10, 16'h00BE, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[7]  = mk(2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 2'b10, 16'h00BE, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[8]  = mk(2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 2'b11, 16'h00BE, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[9]  = mk(2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 2'b11, 16'h00BE, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
      tbl[10] = mk(2'b11, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 2'b11, 16'h00BE, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
      tbl[11] = mk(2'b11, 16'h3333, 16'h4444, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 2'b00, 16'h1111, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
      tbl[12] = mk(2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 2'b00, 16'h2222, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
      tbl[13] = mk(2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 2'b10, 16'h1111, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
      tbl[14] = mk(2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 2'b11, 16'h1111, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
      tbl[15] = mk(2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b0, 2'b11, 16'h1111, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
      tbl[16] = mk(2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0002, 1'b0, 2'b11, 16'h1111, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1);
      tbl[17] = mk(2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0003, 1'b0, 2'b11, 16'h1111, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1);
      tbl[18] = mk(2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0004, 1'b0, 2'b11, 16'h1111, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1);
      tbl[19] = mk(2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0005, 1'b0, 2'b11, 16'h1111, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1);
      tbl[20] = mk(2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 2'b11, 16'h1111, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b1);
      tbl[21] = mk(2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 2'b11, 16'h1111, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1, 1'b1);
      tbl[22] = mk(2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 2'b11, 16'h1111, 1'b1, 16'h0003, 1'b1, 1'b0, 1'b1, 1'b1);
      tbl[23] = mk(2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 2'b11, 16'h1111, 1'b1, 16'h0004, 1'b1, 1'b0, 1'b1, 1'b1);
      tbl[24] = mk(2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 2'b11, 16'h1111, 1'b0, 16'h0004, 1'b1, 1'b0, 1'b1, 1'b1);

      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         drive(tbl[i].iv, tbl[i].d0, tbl[i].d1, tbl[i].ai, tbl[i].rq,
               tbl[i].oe, tbl[i].ao, tbl[i].io, tbl[i].ordy);
         #1;
         chk($sformatf("v%0d.in_ready", i),  32'(bus.in_ready),  32'(tbl[i].e_rdy));
         chk($sformatf("v%0d.io_in", i),     32'(bus.io_in),     32'(tbl[i].e_ioin));
         chk($sformatf("v%0d.out_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_ov));
         chk($sformatf("v%0d.out_data", i),  32'(bus.out_data),  32'(tbl[i].e_od));
         chk($sformatf("v%0d.out_addr", i),  32'(bus.out_addr),  32'(tbl[i].e_oa));
         chk($sformatf("v%0d.itr", i),       32'(bus.itr),       32'(tbl[i].e_itr));
         chk($sformatf("v%0d.ovf", i),       32'(bus.ovf),       32'(tbl[i].e_ovf));
         chk($sformatf("v%0d.udf", i),       32'(bus.udf),       32'(tbl[i].e_udf));
      end

      // Mid-stream reset: channel 0 full and three words queued.
      @(negedge clk);
      drive(2'b01, 16'h5555, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0021 + 16'(i), 1'b0);
      end
      @(negedge clk);
      drive(2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
      #1;
      chk("pre_rst.in_ready",  32'(bus.in_ready),  32'h2);
      chk("pre_rst.out_valid", 32'(bus.out_valid), 32'h1);
      chk("pre_rst.out_data",  32'(bus.out_data),  32'h21);
      chk("pre_rst.io_in",     32'(bus.io_in),     32'h5555);
      rst = 1'b1;
      #1;
      chk("rst.in_ready",  32'(bus.in_ready),  32'h3);
      chk("rst.out_valid", 32'(bus.out_valid), 32'h0);
      chk("rst.out_data",  32'(bus.out_data),  32'h0);
      chk("rst.out_addr",  32'(bus.out_addr),  32'h0);
      chk("rst.io_in",     32'(bus.io_in),     32'h0);
      chk("rst.ovf",       32'(bus.ovf),       32'h0);
      chk("rst.udf",       32'(bus.udf),       32'h0);
      chk("rst.itr",       32'(bus.itr),       32'h0);
      @(negedge clk);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk($sformatf("post_rst%0d.out_valid", i), 32'(bus.out_valid), 32'h0);
         chk($sformatf("post_rst%0d.in_ready", i),  32'(bus.in_ready),  32'h3);
         chk($sformatf("post_rst%0d.io_in", i),     32'(bus.io_in),     32'h0);
      end

      // Full FIFO with simultaneous push and pop.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0031 + 16'(i), 1'b0);
         #1;
         chk($sformatf("fill%0d.ovf", i), 32'(bus.ovf), 32'h0);
      end
      @(negedge clk);
      drive(2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h00AA, 1'b1);
      #1;
      chk("full_pp.out_valid", 32'(bus.out_valid), 32'h1);
      chk("full_pp.out_data",  32'(bus.out_data),  32'h31);
      drain_d[0] = 16'h0032; drain_d[1] = 16'h0033; drain_d[2] = 16'h0034; drain_d[3] = 16'h00AA;
      drain_a[0] = 1'b0;     drain_a[1] = 1'b0;     drain_a[2] = 1'b0;     drain_a[3] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
         #1;
         chk($sformatf("drain%0d.out_valid", i), 32'(bus.out_valid), 32'h1);
         chk($sformatf("drain%0d.out_data", i),  32'(bus.out_data),  32'(drain_d[i]));
         chk($sformatf("drain%0d.out_addr", i),  32'(bus.out_addr),  32'(drain_a[i]));
         chk($sformatf("drain%0d.ovf", i),       32'(bus.ovf),       32'h0);
      end
      @(negedge clk);
      #1;
      chk("drained.out_valid", 32'(bus.out_valid), 32'h0);
      chk("drained.out_data",  32'(bus.out_data),  32'hAA);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
